// File: rtl/note_length_timer_if.sv
// Note request channel from the score reader: length code plus dotted flag, valid/ready handshake.
interface note_length_timer_if #(
  parameter int LEN_W = 3
);
  logic             note_valid;
  logic             note_ready;
  logic [LEN_W-1:0] length;
  logic             dotted;

  modport master (output note_valid, output length, output dotted, input note_ready);
  modport slave  (input note_valid, input length, input dotted, output note_ready);
endinterface

// File: rtl/note_length_timer.sv
// Times one note per accepted code against the tempo tick; note_on rises 1 cycle after accept.
// Accepts only in IDLE (note_ready = IDLE), so the next note can be taken in the note_done cycle.
module note_length_timer #(
  parameter int LEN_W     = 3,
  parameter int CNT_W     = 7,
  parameter int SUBDIV    = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  note_length_timer_if.slave note_if,
  output logic               o_note_on,
  output logic               o_busy,
  output logic               o_note_done,
  output logic               o_len_err,
  output logic [CNT_W-1:0]   o_remaining
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam logic [31:0]      SAT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_rem, w_rem_nx;
  logic             r_note_on, w_on_nx;
  logic             r_done, w_done_nx;
  logic             r_err, w_err_nx;
  logic             r_gap_en, w_gap_en_nx;

  logic [3:0]       w_units;
  logic [31:0]      w_t_full;
  logic [CNT_W-1:0] w_t;
  logic             w_gap_ok;

  always_comb begin
    w_units = 4'd0;
    case (note_if.length)
      LEN_W'(0): w_units = 4'd2;
      LEN_W'(1): w_units = 4'd1;
      LEN_W'(2): w_units = 4'd3;
      LEN_W'(3): w_units = 4'd4;
      LEN_W'(4): w_units = 4'd12;
      default:   w_units = 4'd0;
    endcase
  end

  // Full-width product first so long dotted notes saturate instead of wrapping.
  assign w_t_full = 32'(w_units) * 32'(SUBDIV)
                  + (note_if.dotted ? 32'(w_units) * 32'(SUBDIV / 2) : 32'd0);
  assign w_t      = (w_t_full > SAT_MAX) ? CNT_W'(SAT_MAX) : CNT_W'(w_t_full);
  assign w_gap_ok = (GAP_TICKS != 0) && (w_t > GAP_CNT);

  always_comb begin
    w_state_nx  = r_state;
    w_rem_nx    = r_rem;
    w_on_nx     = 1'b0;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;
    w_gap_en_nx = r_gap_en;
    unique case (r_state)
      S_IDLE: begin
        if (note_if.note_valid) begin
          if (w_units == 4'd0) begin
            w_err_nx = 1'b1;
          end else begin
            w_state_nx  = S_PLAY;
            w_on_nx     = 1'b1;
            w_gap_en_nx = w_gap_ok;
            w_rem_nx    = w_gap_ok ? (w_t - GAP_CNT) : w_t;
          end
        end
      end
      S_PLAY: begin
        w_on_nx = 1'b1;
        if (i_tick) begin
          if (r_rem == ONE) begin
            w_on_nx = 1'b0;
            if (r_gap_en) begin
              w_state_nx = S_GAP;
              w_rem_nx   = GAP_CNT;
            end else begin
              w_state_nx = S_IDLE;
              w_rem_nx   = '0;
              w_done_nx  = 1'b1;
            end
          end else begin
            w_rem_nx = r_rem - ONE;
          end
        end
      end
      S_GAP: begin
        if (i_tick) begin
          if (r_rem == ONE) begin
            w_state_nx = S_IDLE;
            w_rem_nx   = '0;
            w_done_nx  = 1'b1;
          end else begin
            w_rem_nx = r_rem - ONE;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_rem_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_note_on <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_gap_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rem     <= w_rem_nx;
      r_note_on <= w_on_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_gap_en  <= w_gap_en_nx;
    end
  end

  assign note_if.note_ready = (r_state == S_IDLE);
  assign o_busy             = (r_state != S_IDLE);
  assign o_note_on          = r_note_on;
  assign o_note_done        = r_done;
  assign o_len_err          = r_err;
  assign o_remaining        = r_rem;

endmodule

// File: tb/tb_note_length_timer.sv
// Directed bench: default timer (A), SUBDIV=2/GAP=4 timer (B), SUBDIV=16/no-gap timer (C) for saturation.
module tb_note_length_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  note_length_timer_if #(.LEN_W(3)) ifa ();
  note_length_timer_if #(.LEN_W(3)) ifb ();
  note_length_timer_if #(.LEN_W(3)) ifc ();

  logic       a_on, a_busy, a_done, a_err;
  logic [6:0] a_rem;
  logic       b_on, b_busy, b_done, b_err;
  logic [6:0] b_rem;
  logic       c_on, c_busy, c_done, c_err;
  logic [6:0] c_rem;

  note_length_timer dut_a (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .note_if(ifa),
    .o_note_on(a_on), .o_busy(a_busy), .o_note_done(a_done),
    .o_len_err(a_err), .o_remaining(a_rem)
  );

  note_length_timer #(.SUBDIV(2), .GAP_TICKS(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .note_if(ifb),
    .o_note_on(b_on), .o_busy(b_busy), .o_note_done(b_done),
    .o_len_err(b_err), .o_remaining(b_rem)
  );

  note_length_timer #(.SUBDIV(16), .GAP_TICKS(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .note_if(ifc),
    .o_note_on(c_on), .o_busy(c_busy), .o_note_done(c_done),
    .o_len_err(c_err), .o_remaining(c_rem)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n, on_cnt, gap_cnt, done_cnt, done_idx, maxrem;

  int         exp_rem1  [4] = '{2, 1, 1, 0};
  int         exp_on1   [4] = '{1, 1, 0, 0};
  int         exp_done1 [4] = '{0, 0, 0, 1};
  logic [2:0] bb_len    [3] = '{3'd1, 3'd0, 3'd2};
  int         bb_t      [3] = '{4, 8, 12};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.note_valid = 1'b0; ifa.length = 3'd0; ifa.dotted = 1'b0;
    ifb.note_valid = 1'b0; ifb.length = 3'd0; ifb.dotted = 1'b0;
    ifc.note_valid = 1'b0; ifc.length = 3'd0; ifc.dotted = 1'b0;
    #22 rst = 1'b0;
    cyc();

    // reset state
    chk("rst_on",    32'(a_on), 0);
    chk("rst_busy",  32'(a_busy), 0);
    chk("rst_done",  32'(a_done), 0);
    chk("rst_err",   32'(a_err), 0);
    chk("rst_rem",   32'(a_rem), 0);
    chk("rst_ready", 32'(ifa.note_ready), 1);

    // length=1, tick every 5 clocks: T=4 -> 3 play ticks + 1 gap tick
    ifa.note_valid = 1'b1; ifa.length = 3'd1; ifa.dotted = 1'b0;
    cyc();
    ifa.note_valid = 1'b0;
    chk("t1_on0",   32'(a_on), 1);
    chk("t1_rem0",  32'(a_rem), 3);
    chk("t1_busy0", 32'(a_busy), 1);
    chk("t1_rdy0",  32'(ifa.note_ready), 0);
    for (int k = 0; k < 4; k++) begin
      repeat (4) cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk($sformatf("t1_rem%0d", k + 1), 32'(a_rem), 32'(exp_rem1[k]));
      chk($sformatf("t1_on%0d", k + 1), 32'(a_on), 32'(exp_on1[k]));
      chk($sformatf("t1_done%0d", k + 1), 32'(a_done), 32'(exp_done1[k]));
    end
    cyc();
    chk("t1_done_pulse", 32'(a_done), 0);

    // length=4 dotted: T=72, tick high, tick in accept cycle must be ignored
    tick = 1'b1;
    ifa.note_valid = 1'b1; ifa.length = 3'd4; ifa.dotted = 1'b1;
    cyc();
    ifa.note_valid = 1'b0; ifa.dotted = 1'b0;
    chk("t2_rem0", 32'(a_rem), 71);
    on_cnt = 0; done_cnt = 0; done_idx = -1; maxrem = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_on) on_cnt++;
      if (a_done) begin done_cnt++; done_idx = i; end
      if (int'(a_rem) > maxrem) maxrem = int'(a_rem);
      cyc();
    end
    tick = 1'b0;
    chk("t2_on_ticks", 32'(on_cnt), 71);
    chk("t2_done_cnt", 32'(done_cnt), 1);
    chk("t2_done_idx", 32'(done_idx), 72);
    chk("t2_max_rem",  32'(maxrem), 71);

    // invalid codes 5 and 7
    for (int k = 0; k < 2; k++) begin
      ifa.note_valid = 1'b1; ifa.length = (k == 0) ? 3'd5 : 3'd7;
      cyc();
      ifa.note_valid = 1'b0;
      chk("t3_err",  32'(a_err), 1);
      chk("t3_busy", 32'(a_busy), 0);
      chk("t3_rdy",  32'(ifa.note_ready), 1);
      chk("t3_on",   32'(a_on), 0);
      chk("t3_done", 32'(a_done), 0);
      cyc();
      chk("t3_err_pulse", 32'(a_err), 0);
    end

    // SUBDIV=2, GAP=4, length=1: T=2 <= 4 so no gap
    tick = 1'b1;
    ifb.note_valid = 1'b1; ifb.length = 3'd1; ifb.dotted = 1'b0;
    cyc();
    ifb.note_valid = 1'b0;
    chk("t4_rem0", 32'(b_rem), 2);
    on_cnt = 0; gap_cnt = 0; n = 0;
    while (!b_done && n < 20) begin
      if (b_on) on_cnt++;
      if (!b_on && b_busy) gap_cnt++;
      n++;
      cyc();
    end
    tick = 1'b0;
    chk("t4_done",   32'(b_done), 1);
    chk("t4_on_cnt", 32'(on_cnt), 2);
    chk("t4_gap",    32'(gap_cnt), 0);
    chk("t4_len",    32'(n), 2);
    // dotted 12 units at SUBDIV=2: T=36, minus gap 4
    ifb.note_valid = 1'b1; ifb.length = 3'd4; ifb.dotted = 1'b1;
    cyc();
    ifb.note_valid = 1'b0;
    chk("t4_dot_rem", 32'(b_rem), 32);

    // saturation: 12 units * 16 * 1.5 = 288 -> 127
    ifc.note_valid = 1'b1; ifc.length = 3'd4; ifc.dotted = 1'b1;
    cyc();
    ifc.note_valid = 1'b0;
    chk("sat_rem", 32'(c_rem), 127);

    // back-to-back with tick tied high, next note offered in each done cycle
    repeat (3) cyc();
    tick = 1'b1;
    ifa.note_valid = 1'b1; ifa.length = bb_len[0]; ifa.dotted = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      ifa.note_valid = 1'b0;
      n = 0;
      while (!a_done && n < 40) begin
        if (a_busy) n++;
        cyc();
      end
      chk($sformatf("bb_dur%0d", k), 32'(n), 32'(bb_t[k]));
      chk($sformatf("bb_done%0d", k), 32'(a_done), 1);
      chk($sformatf("bb_rdy%0d", k), 32'(ifa.note_ready), 1);
      if (k < 2) begin
        ifa.note_valid = 1'b1; ifa.length = bb_len[k + 1];
      end
    end
    tick = 1'b0;
    cyc();
    chk("bb_idle_done", 32'(a_done), 0);
    chk("bb_idle_busy", 32'(a_busy), 0);

    // asynchronous reset mid-note at remaining=20
    ifa.note_valid = 1'b1; ifa.length = 3'd4; ifa.dotted = 1'b0;
    cyc();
    ifa.note_valid = 1'b0;
    chk("t6_rem0", 32'(a_rem), 47);
    tick = 1'b1;
    repeat (27) cyc();
    tick = 1'b0;
    chk("t6_rem20", 32'(a_rem), 20);
    chk("t6_on",    32'(a_on), 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_on",   32'(a_on), 0);
    chk("t6_rst_busy", 32'(a_busy), 0);
    chk("t6_rst_rem",  32'(a_rem), 0);
    chk("t6_rst_rdy",  32'(ifa.note_ready), 1);
    chk("t6_rst_done", 32'(a_done), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    chk("t6_post_done", 32'(a_done), 0);
    chk("t6_post_err",  32'(a_err), 0);
    ifa.note_valid = 1'b1; ifa.length = 3'd2; ifa.dotted = 1'b0;
    cyc();
    ifa.note_valid = 1'b0;
    chk("t6_next_rem", 32'(a_rem), 11);
    chk("t6_next_on",  32'(a_on), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_length_timer.md
Name: note_length_timer

Overview:
- Parametrised note-duration engine for the music game.
- Accepts a note length code through a valid/ready handshake and decodes it to length units: 2, 1, 3, 4 or 12 units, or invalid.
- Applies an optional dotted extension (x1.5) and times the note against the tempo tick, producing a gated note_on with an articulation gap and a completion pulse.
- Sits between the score/sequencer ROM reader and the tone generator / hit-window logic.

Parameters:
- LEN_W, 3: width of the length code.
- CNT_W, 7: width of the tick counter and of remaining.
- SUBDIV, 4: tick pulses per length unit. Must be even and at least 2.
- GAP_TICKS, 1: ticks of silence (note_on low) at the end of each note. 0 disables the gap.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- tick, in, 1: single-cycle tempo pulse, one per 1/SUBDIV unit.
- note_valid, in, 1: a new note is presented.
- note_ready, out, 1: block can accept a note.
- length, in, LEN_W: note length code.
- dotted, in, 1: extend the note duration by half.
- note_on, out, 1: tone gate.
- busy, out, 1: a note is in progress (state is not IDLE).
- note_done, out, 1: one-cycle pulse when a note completes.
- len_err, out, 1: one-cycle pulse when an invalid code is accepted.
- remaining, out, CNT_W: ticks left in the current phase.

Behaviour:
- Reset (asynchronous, any state): state IDLE, note_on=0, busy=0, note_done=0, len_err=0, remaining=0, note_ready=1.
- Decode table (code -> units): 0->2, 1->1, 2->3, 3->4, 4->12, all other codes -> 0 (invalid).
- Total ticks:
  - T = u*SUBDIV, plus u*SUBDIV/2 when dotted=1.
  - Compute at full width, then saturate to 2^CNT_W-1.
- Accept: when note_valid && note_ready on a rising edge, length and dotted are captured.
  - Any tick in the accept cycle is ignored.
- FSM states IDLE, PLAY, GAP.
- IDLE:
  - note_ready=1, note_on=0.
  - On accept with u=0: len_err=1 for the next cycle, stay in IDLE, no note_done.
  - On accept with u>0 and (GAP_TICKS=0 or T<=GAP_TICKS): go to PLAY with remaining=T, and the GAP phase is skipped.
  - On accept otherwise: go to PLAY with remaining=T-GAP_TICKS.
- PLAY:
  - note_on=1, note_ready=0.
  - Each tick decrements remaining.
  - On a tick with remaining==1: if the gap is enabled for this note, go to GAP with remaining=GAP_TICKS, note_on=0 from the next cycle.
  - Otherwise go to IDLE with note_done=1 for one cycle.
- GAP:
  - note_on=0.
  - Each tick decrements remaining.
  - On a tick with remaining==1: go to IDLE, note_done=1 for one cycle, remaining=0.
- Latency:
  - note_on rises 1 cycle after the accept edge.
  - The note occupies exactly T tick pulses from the first tick after acceptance to the note_done cycle.
  - The ticks in PLAY plus the ticks in GAP equal T.
- Back-to-back notes:
  - note_ready is high in the note_done cycle (FSM is already in IDLE), so the next note can be accepted there.
  - Zero dead ticks between notes.
- tick held high continuously: one decrement per clock. This is legal and used for fast simulation.
- All outputs are registered except note_ready and busy, which decode directly from the state register.
- note_valid while not ready is ignored. It is not queued.
- Reset asserted mid-note: immediate return to the reset values. No note_done or len_err pulse is generated.

Test Plan:
- Defaults; length=1, dotted=0, tick every 5 clocks -> T=4: note_on high for 3 ticks, low for 1 tick, note_done 1 cycle after the 4th tick edge, remaining sequence 3,2,1,1,0.
- length=4, dotted=1 -> T=72: note_on high for 71 ticks, gap of 1 tick, single note_done; remaining never exceeds 71.
- length=5 and length=7 presented -> len_err pulse 1 cycle each, busy stays 0, note_ready stays 1, note_on stays 0.
- GAP_TICKS=4, SUBDIV=2, length=1 (T=2<=4) -> no gap: note_on high for 2 ticks, then note_done.
- tick tied high; codes 1,0,2 fed back-to-back, each presented in the note_done cycle -> PLAY+GAP durations of 4, 8 and 12 clocks with no idle clocks between notes, 3 note_done pulses.
- rst pulsed asynchronously (mid-clock) while in PLAY with remaining=20 -> all outputs at reset values immediately, no note_done; next note decodes normally.
